// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C register master.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StSendByte,
        StGetAck,
        StRstart,
        StRecvByte,
        StSendNack,
        StStop,
        StDone
    } state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h68;

    // Quarter phases of one SCL period.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_byte_master_if.sv
// Command/status handshake between a requester and the I2C byte master.
interface i2c_byte_master_if;

    logic       start;
    logic       re;
    logic       we;
    logic [7:0] address;
    logic [7:0] we_data;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       we_success;
    logic       nack;

    modport master (
        output start, re, we, address, we_data,
        input  rd_data, busy, done, we_success, nack
    );

    modport slave (
        input  start, re, we, address, we_data,
        output rd_data, busy, done, we_success, nack
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL strobe generator: one tick every CLK_DIV cycles plus a 2-bit phase.
module i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int unsigned    CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      phase_q, phase_d;

    assign tick  = enable && (cnt_q == CntMax);
    assign phase = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!enable) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C register read/write master with open-drain SCL/SDA.
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int unsigned CLK_DIV  = 125
) (
    input  logic             clock,
    input  logic             reset,
    i2c_byte_master_if.slave bus,
    inout  wire              scl,
    inout  wire              sda
);

    state_e     state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       is_read_q, is_read_d;
    logic       ack_err_q, ack_err_d;
    logic       scl_low_q, scl_low_d;
    logic       sda_low_q, sda_low_d;
    logic       we_success_q, we_success_d;
    logic       nack_q, nack_d;

    logic       busy;
    logic       tick;
    logic [1:0] phase;
    logic       sda_in;

    assign busy   = (state_q != StIdle);
    assign sda_in = sda;

    // Open-drain: only ever pull low or release.
    assign scl = scl_low_q ? 1'b0 : 1'bz;
    assign sda = sda_low_q ? 1'b0 : 1'bz;

    assign bus.busy       = busy;
    assign bus.done       = (state_q == StDone);
    assign bus.rd_data    = rd_data_q;
    assign bus.we_success = we_success_q;
    assign bus.nack       = nack_q;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .enable (busy),
        .tick   (tick),
        .phase  (phase)
    );

    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        rx_d         = rx_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rd_data_d    = rd_data_q;
        is_read_d    = is_read_q;
        ack_err_d    = ack_err_q;
        scl_low_d    = scl_low_q;
        sda_low_d    = sda_low_q;
        we_success_d = we_success_q;
        nack_d       = nack_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start && (bus.re ^ bus.we)) begin
                    state_d      = StStart;
                    is_read_d    = bus.re;
                    addr_d       = bus.address;
                    data_d       = bus.we_data;
                    shift_d      = {DEV_ADDR, RW_WRITE};
                    idx_d        = 2'd0;
                    ack_err_d    = 1'b0;
                    we_success_d = 1'b0;
                    nack_d       = 1'b0;
                end
            end
            // START and repeated START share one waveform: SDA falls with SCL released.
            StStart, StRstart: begin
                if (tick) begin
                    unique case (phase)
                        Q0: sda_low_d = 1'b0;
                        Q1: scl_low_d = 1'b0;
                        Q2: sda_low_d = 1'b1;
                        Q3: begin
                            scl_low_d = 1'b1;
                            bit_d     = 3'd7;
                            state_d   = StSendByte;
                        end
                    endcase
                end
            end
            StSendByte: begin
                if (tick) begin
                    unique case (phase)
                        Q0: sda_low_d = ~shift_q[7];
                        Q1: scl_low_d = 1'b0;
                        Q2: ;
                        Q3: begin
                            scl_low_d = 1'b1;
                            if (bit_q == 3'd0) begin
                                state_d = StGetAck;
                            end else begin
                                bit_d   = bit_q - 3'd1;
                                shift_d = {shift_q[6:0], 1'b0};
                            end
                        end
                    endcase
                end
            end
            StGetAck: begin
                if (tick) begin
                    unique case (phase)
                        Q0: sda_low_d = 1'b0;
                        Q1: scl_low_d = 1'b0;
                        Q2: ack_err_d = sda_in;
                        Q3: begin
                            scl_low_d = 1'b1;
                            idx_d     = idx_q + 2'd1;
                            bit_d     = 3'd7;
                            if (ack_err_q) begin
                                state_d = StStop;
                            end else begin
                                unique case (idx_q)
                                    2'd0: begin
                                        shift_d = addr_q;
                                        state_d = StSendByte;
                                    end
                                    2'd1: begin
                                        if (is_read_q) begin
                                            shift_d = {DEV_ADDR, RW_READ};
                                            state_d = StRstart;
                                        end else begin
                                            shift_d = data_q;
                                            state_d = StSendByte;
                                        end
                                    end
                                    default: state_d = is_read_q ? StRecvByte : StStop;
                                endcase
                            end
                        end
                    endcase
                end
            end
            StRecvByte: begin
                if (tick) begin
                    unique case (phase)
                        Q0: sda_low_d = 1'b0;
                        Q1: scl_low_d = 1'b0;
                        Q2: rx_d      = {rx_q[6:0], sda_in};
                        Q3: begin
                            scl_low_d = 1'b1;
                            if (bit_q == 3'd0) begin
                                state_d = StSendNack;
                            end else begin
                                bit_d = bit_q - 3'd1;
                            end
                        end
                    endcase
                end
            end
            StSendNack: begin
                if (tick) begin
                    unique case (phase)
                        Q0: sda_low_d = 1'b0;
                        Q1: scl_low_d = 1'b0;
                        Q2: ;
                        Q3: begin
                            scl_low_d = 1'b1;
                            state_d   = StStop;
                        end
                    endcase
                end
            end
            StStop: begin
                if (tick) begin
                    unique case (phase)
                        Q0: sda_low_d = 1'b1;
                        Q1: scl_low_d = 1'b0;
                        Q2: sda_low_d = 1'b0;
                        Q3: begin
                            state_d      = StDone;
                            nack_d       = ack_err_q;
                            we_success_d = !ack_err_q && !is_read_q;
                            if (is_read_q && !ack_err_q) begin
                                rd_data_d = rx_q;
                            end
                        end
                    endcase
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            bit_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            rx_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            rd_data_q    <= '0;
            is_read_q    <= 1'b0;
            ack_err_q    <= 1'b0;
            scl_low_q    <= 1'b0;
            sda_low_q    <= 1'b0;
            we_success_q <= 1'b0;
            nack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            rx_q         <= rx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rd_data_q    <= rd_data_d;
            is_read_q    <= is_read_d;
            ack_err_q    <= ack_err_d;
            scl_low_q    <= scl_low_d;
            sda_low_q    <= sda_low_d;
            we_success_q <= we_success_d;
            nack_q       <= nack_d;
        end
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Scoreboard bench: expected bus tokens and done results are queued at issue, monitors pop them.
module tb_i2c_byte_master;

    localparam int unsigned CLK_DIV = 4;
    localparam int          TOK_S   = 1000;
    localparam int          TOK_P   = 2000;
    localparam int          WR_LAT  = 116 * CLK_DIV;

    typedef struct {
        logic       ws;
        logic       nk;
        logic [7:0] rd;
        int         issue_cyc;
        bit         lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    wire  scl;
    wire  sda;

    i2c_byte_master_if ifc ();

    pullup pu_scl (scl);
    pullup pu_sda (sda);

    i2c_byte_master #(
        .DEV_ADDR (7'h68),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave),
        .scl   (scl),
        .sda   (sda)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   tok_seen = 0;
    exp_t exp_q[$];
    int   exp_bus[$];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endfunction

    // ---------------- slave model: acks address 0x68, serves s_tx on reads
    logic       slave_present;
    logic [7:0] s_tx;
    logic       s_pull = 1'b0;
    logic       s_prev_scl = 1'b1, s_prev_sda = 1'b1;
    logic [7:0] s_sh = 8'h00;
    int         s_bitn = 0;
    logic       s_addr_phase = 1'b0, s_rd = 1'b0;
    logic       s_c, s_d;

    assign sda = (s_pull && !reset) ? 1'b0 : 1'bz;

    always begin
        @(posedge clock);
        #2;
        s_c = (scl !== 1'b0);
        s_d = (sda !== 1'b0);
        if (reset) begin
            s_pull = 1'b0; s_bitn = 0; s_addr_phase = 1'b0; s_rd = 1'b0;
        end else if (s_prev_scl && s_c && s_prev_sda && !s_d) begin
            s_bitn = 0; s_addr_phase = 1'b1; s_rd = 1'b0; s_pull = 1'b0;
        end else if (s_prev_scl && s_c && !s_prev_sda && s_d) begin
            s_bitn = 0; s_addr_phase = 1'b0; s_rd = 1'b0; s_pull = 1'b0;
        end else if (!s_prev_scl && s_c) begin
            if (s_bitn < 8) s_sh = {s_sh[6:0], s_d};
            s_bitn++;
        end else if (s_prev_scl && !s_c) begin
            if (s_bitn == 8) begin
                if (s_addr_phase) begin
                    s_rd         = s_sh[0];
                    s_addr_phase = 1'b0;
                    s_pull       = slave_present && (s_sh[7:1] == 7'h68);
                end else begin
                    s_pull = slave_present && !s_rd;
                    s_rd   = 1'b0;
                end
            end else if (s_bitn == 9) begin
                s_bitn = 0;
                s_pull = slave_present && s_rd && !s_tx[7];
            end else if (s_rd && s_bitn >= 1 && s_bitn <= 7) begin
                s_pull = slave_present && !s_tx[7 - s_bitn];
            end
        end
        s_prev_scl = s_c;
        s_prev_sda = s_d;
    end

    // ---------------- bus monitor: decodes START/STOP/bytes into tokens
    logic       m_prev_scl = 1'b1, m_prev_sda = 1'b1;
    logic [8:0] m_sh = 9'h0;
    int         m_cnt = 0;
    logic       m_c, m_d;

    function automatic void bus_token(input int tok);
        tok_seen++;
        checks++;
        if (exp_bus.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected_token got=%0h expected=none", tok);
        end else begin
            int e;
            e = exp_bus.pop_front();
            if (e != tok) begin
                errors++;
                $display("FAIL bus_token got=%0h expected=%0h", tok, e);
            end
        end
    endfunction

    always @(negedge clock) begin
        m_c = (scl !== 1'b0);
        m_d = (sda !== 1'b0);
        if (reset) begin
            m_cnt = 0;
        end else if (m_prev_scl && m_c && (m_d != m_prev_sda)) begin
            m_cnt = 0;
            bus_token(m_d ? TOK_P : TOK_S);
        end else if (!m_prev_scl && m_c) begin
            m_sh = {m_sh[7:0], m_d};
            m_cnt++;
            if (m_cnt == 9) begin
                m_cnt = 0;
                bus_token(int'({m_sh[0], m_sh[8:1]}));
            end
        end
        m_prev_scl = m_c;
        m_prev_sda = m_d;
    end

    // ---------------- done monitor
    always @(negedge clock) begin
        if (!reset && ifc.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got=done expected=none");
            end else begin
                exp_t e;
                int   lat;
                e = exp_q.pop_front();
                if ({ifc.we_success, ifc.nack, ifc.rd_data} !== {e.ws, e.nk, e.rd}) begin
                    errors++;
                    $display("FAIL done_result got ws=%0b nack=%0b rd=%0h expected ws=%0b nack=%0b rd=%0h",
                             ifc.we_success, ifc.nack, ifc.rd_data, e.ws, e.nk, e.rd);
                end
                if (e.lat) begin
                    lat = cyc - e.issue_cyc - 1;
                    checks++;
                    if (lat < WR_LAT - 1 || lat > WR_LAT + 1) begin
                        errors++;
                        $display("FAIL write_latency got=%0d expected=%0d", lat, WR_LAT);
                    end
                end
            end
        end
    end

    // ---------------- stimulus
    task automatic issue(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input bit push, input logic ws, input logic nk, input logic [7:0] rd,
                         input bit lat);
        exp_t e;
        @(negedge clock);
        ifc.start = 1'b1; ifc.re = r; ifc.we = w; ifc.address = a; ifc.we_data = d;
        if (push) begin
            e.ws = ws; e.nk = nk; e.rd = rd; e.issue_cyc = cyc; e.lat = lat;
            exp_q.push_back(e);
        end
        @(negedge clock);
        ifc.start = 1'b0; ifc.re = 1'b0; ifc.we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ifc.busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout got=busy expected=idle", name);
        end
        chk({name, "_bus_drained"}, exp_bus.size(), 0);
    endtask

    task automatic push_write_bus(input logic [7:0] a, input logic [7:0] d);
        exp_bus.push_back(TOK_S);
        exp_bus.push_back(32'h0D0);
        exp_bus.push_back(int'({1'b0, a}));
        exp_bus.push_back(int'({1'b0, d}));
        exp_bus.push_back(TOK_P);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base;
        reset = 1'b1;
        ifc.start = 1'b0; ifc.re = 1'b0; ifc.we = 1'b0;
        ifc.address = 8'h00; ifc.we_data = 8'h00;
        slave_present = 1'b1;
        s_tx = 8'hA5;
        repeat (3) @(negedge clock);
        chk("rst_scl", scl !== 1'b0, 1);
        chk("rst_sda", sda !== 1'b0, 1);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_we_success", ifc.we_success, 0);
        chk("rst_nack", ifc.nack, 0);
        chk("rst_rd_data", ifc.rd_data, 8'h00);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Write 6B<-00; a start while busy and a start in the DONE cycle are both ignored.
        push_write_bus(8'h6B, 8'h00);
        issue(1'b0, 1'b1, 8'h6B, 8'h00, 1, 1'b1, 1'b0, 8'h00, 1);
        repeat (100) @(negedge clock);
        issue(1'b1, 1'b0, 8'h3B, 8'h11, 0, 1'b0, 1'b0, 8'h00, 0);
        n = 0;
        while (!ifc.done && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL write1_done_timeout got=no_done expected=done");
        end
        ifc.start = 1'b1; ifc.we = 1'b1; ifc.address = 8'h55; ifc.we_data = 8'h77;
        @(negedge clock);
        ifc.start = 1'b0; ifc.we = 1'b0;
        repeat (3) @(negedge clock);
        chk("start_in_done_ignored", ifc.busy, 0);
        wait_idle("write1");

        // re and we both high: not accepted.
        issue(1'b1, 1'b1, 8'h22, 8'h33, 0, 1'b0, 1'b0, 8'h00, 0);
        repeat (40) @(negedge clock);
        chk("both_rw_ignored", ifc.busy, 0);

        // Register read of 3B, slave returns A5.
        s_tx = 8'hA5;
        exp_bus.push_back(TOK_S);
        exp_bus.push_back(32'h0D0);
        exp_bus.push_back(32'h03B);
        exp_bus.push_back(TOK_S);
        exp_bus.push_back(32'h0D1);
        exp_bus.push_back(32'h1A5);
        exp_bus.push_back(TOK_P);
        issue(1'b1, 1'b0, 8'h3B, 8'h00, 1, 1'b0, 1'b0, 8'hA5, 0);
        wait_idle("read1");
        chk("rd_data_holds", ifc.rd_data, 8'hA5);

        // No slave: NACK on the address byte, STOP immediately.
        slave_present = 1'b0;
        exp_bus.push_back(TOK_S);
        exp_bus.push_back(32'h1D0);
        exp_bus.push_back(TOK_P);
        issue(1'b0, 1'b1, 8'h6B, 8'h12, 1, 1'b0, 1'b1, 8'hA5, 0);
        wait_idle("noslave");
        chk("noslave_scl_released", scl !== 1'b0, 1);
        chk("noslave_sda_released", sda !== 1'b0, 1);
        slave_present = 1'b1;

        // Reset during the data byte of a read.
        s_tx = 8'h5A;
        exp_bus.push_back(TOK_S);
        exp_bus.push_back(32'h0D0);
        exp_bus.push_back(32'h03B);
        exp_bus.push_back(TOK_S);
        exp_bus.push_back(32'h0D1);
        base = tok_seen;
        issue(1'b1, 1'b0, 8'h3B, 8'h00, 1, 1'b0, 1'b0, 8'h5A, 0);
        n = 0;
        while (tok_seen < base + 5 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL read2_header_timeout got=%0d expected=%0d", tok_seen - base, 5);
        end
        repeat (40) @(negedge clock);
        chk("abort_in_recv_busy", ifc.busy, 1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_bus.delete();
        #1;
        chk("abort_scl_released", scl !== 1'b0, 1);
        chk("abort_sda_released", sda !== 1'b0, 1);
        chk("abort_busy", ifc.busy, 0);
        chk("abort_done", ifc.done, 0);
        @(negedge clock);
        chk("abort_rd_data", ifc.rd_data, 8'h00);
        chk("abort_nack", ifc.nack, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Normal write after the abort.
        push_write_bus(8'h10, 8'h5C);
        issue(1'b0, 1'b1, 8'h10, 8'h5C, 1, 1'b1, 1'b0, 8'h00, 1);
        wait_idle("write2");

        repeat (20) @(negedge clock);
        chk("final_exp_q_empty", exp_q.size(), 0);
        chk("final_bus_q_empty", exp_bus.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
